// File: rtl/apu_pkg.sv
// Shared definitions for the multi-voice audio unit: waveform encodings,
// sample width and the noise LFSR polynomial.
package apu_pkg;

  typedef enum logic [1:0] {
    MODE_SAW      = 2'b00,
    MODE_SQUARE   = 2'b01,
    MODE_TRIANGLE = 2'b10,
    MODE_NOISE    = 2'b11
  } wave_mode_e;

  localparam int SAMPLE_BITS = 8;
  localparam int LFSR_BITS   = 13;

  // Feedback taps 12, 8, 2, 0; XNOR feedback so the all-ones state is the lockup.
  localparam logic [LFSR_BITS-1:0] LFSR_TAPS         = 13'b1_0001_0000_0101;
  localparam logic [LFSR_BITS-1:0] LFSR_DEFAULT_SEED = 13'h0E1F;

  function automatic logic [LFSR_BITS-1:0] lfsr_next(input logic [LFSR_BITS-1:0] s);
    logic fb;
    fb = ~(^(s & LFSR_TAPS));
    return {s[LFSR_BITS-2:0], fb};
  endfunction

endpackage

// File: rtl/apu_voice.sv
// One tone voice: period divider, 8-bit phase, decaying envelope,
// waveform shaping and envelope scaling into a registered sample.
module apu_voice
  import apu_pkg::*;
#(
  parameter int ENV_BITS    = 5,
  parameter int PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   trigger,
  input  logic                   cfg_we,
  input  wave_mode_e             cfg_mode,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic [SAMPLE_BITS-1:0] noise_in,
  output logic                   busy,
  output logic [SAMPLE_BITS-1:0] sample
);

  localparam logic [ENV_BITS-1:0]    ENV_FULL   = '1;
  localparam logic [ENV_BITS-1:0]    ENV_ONE    = ENV_BITS'(1);
  localparam logic [PERIOD_BITS-1:0] PERIOD_ONE = PERIOD_BITS'(1);
  localparam logic [SAMPLE_BITS-1:0] PHASE_ONE  = SAMPLE_BITS'(1);
  localparam int                     PROD_BITS  = SAMPLE_BITS + ENV_BITS;

  wave_mode_e             mode;
  logic [PERIOD_BITS-1:0] period_q;
  logic [PERIOD_BITS-1:0] period_pend;
  logic [PERIOD_BITS-1:0] pend_eff;
  logic [PERIOD_BITS-1:0] div;
  logic [SAMPLE_BITS-1:0] phase;
  logic [SAMPLE_BITS-1:0] noise_q;
  logic [ENV_BITS-1:0]    env;
  logic [SAMPLE_BITS-1:0] raw;
  logic [PROD_BITS-1:0]   product;

  // A write in the same cycle as a reload is the period that reload picks up.
  always_comb begin
    pend_eff = period_pend;
    if (cfg_we) begin
      pend_eff = cfg_period;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode        <= MODE_SAW;
      period_q    <= '0;
      period_pend <= '0;
      div         <= '0;
      phase       <= '0;
      noise_q     <= '0;
    end else begin
      if (cfg_we) begin
        mode        <= cfg_mode;
        period_pend <= cfg_period;
      end
      // A stopped voice (period 0) has no reload to wait for, so it starts at once.
      if (period_q == '0) begin
        period_q <= pend_eff;
      end else if (div == '0) begin
        period_q <= pend_eff;
        div      <= (pend_eff == '0) ? '0 : pend_eff - PERIOD_ONE;
        phase    <= phase + PHASE_ONE;
        noise_q  <= noise_in;
      end else begin
        div <= div - PERIOD_ONE;
      end
    end
  end

  // Trigger wins over a coincident frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env <= '0;
    end else if (trigger) begin
      env <= ENV_FULL;
    end else if (frame_tick && (env != '0)) begin
      env <= env - ENV_ONE;
    end
  end

  always_comb begin
    raw = '0;
    case (mode)
      MODE_SAW:      raw = phase;
      MODE_SQUARE:   raw = {SAMPLE_BITS{phase[SAMPLE_BITS-1]}};
      MODE_TRIANGLE: raw = phase[SAMPLE_BITS-1] ? ~{phase[SAMPLE_BITS-2:0], 1'b0}
                                                :  {phase[SAMPLE_BITS-2:0], 1'b0};
      MODE_NOISE:    raw = noise_q;
      default:       raw = '0;
    endcase
    if (period_q == '0) begin
      raw = '0;
    end
  end

  always_comb begin
    product = {{ENV_BITS{1'b0}}, raw} * {{SAMPLE_BITS{1'b0}}, env};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample <= '0;
    end else begin
      sample <= product[ENV_BITS +: SAMPLE_BITS];
    end
  end

  assign busy = (env != '0);

endmodule

// File: rtl/multi_voice_apu.sv
// Multi-voice audio unit: NUM_VOICES tone voices sharing a noise LFSR,
// summed into an unsigned mix and rendered as a 1-bit PWM output.
module multi_voice_apu
  import apu_pkg::*;
#(
  parameter int                    NUM_VOICES  = 4,
  parameter int                    ENV_BITS    = 5,
  parameter int                    PERIOD_BITS = 16,
  parameter logic [LFSR_BITS-1:0]  LFSR_SEED   = LFSR_DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_VOICES-1:0]  trigger,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_voice,
  input  logic [1:0]             cfg_mode,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  output logic [NUM_VOICES-1:0]  busy,
  output logic                   sound
);

  localparam int                  MIX_BITS = SAMPLE_BITS + $clog2(NUM_VOICES);
  localparam logic [MIX_BITS-1:0] CNT_ONE  = MIX_BITS'(1);

  logic [LFSR_BITS-1:0]   lfsr;
  logic [SAMPLE_BITS-1:0] samples [NUM_VOICES];
  logic [MIX_BITS-1:0]    mix_sum;
  logic [MIX_BITS-1:0]    mix;
  logic [MIX_BITS-1:0]    pwm_cnt;
  logic [MIX_BITS-1:0]    pwm_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Writes addressed past the last voice match no generate index and are dropped.
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    localparam logic [2:0] VIDX = 3'(i);
    logic voice_we;

    assign voice_we = cfg_we && (cfg_voice == VIDX);

    apu_voice #(
      .ENV_BITS    (ENV_BITS),
      .PERIOD_BITS (PERIOD_BITS)
    ) u_voice (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .trigger    (trigger[i]),
      .cfg_we     (voice_we),
      .cfg_mode   (wave_mode_e'(cfg_mode)),
      .cfg_period (cfg_period),
      .noise_in   (lfsr[SAMPLE_BITS-1:0]),
      .busy       (busy[i]),
      .sample     (samples[i])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + MIX_BITS'(samples[i]);
    end
  end

  // The level only changes at counter wrap so each PWM period is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix       <= '0;
      pwm_cnt   <= '0;
      pwm_level <= '0;
      sound     <= 1'b0;
    end else begin
      mix     <= mix_sum;
      pwm_cnt <= pwm_cnt + CNT_ONE;
      if (pwm_cnt == '0) begin
        pwm_level <= mix;
      end
      sound <= (pwm_cnt < pwm_level);
    end
  end

endmodule

// File: tb/tb_multi_voice_apu.sv
// Directed bench for multi_voice_apu with default parameters (4 voices,
// 5-bit envelope, 10-bit mix/PWM).
module tb_multi_voice_apu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  trigger = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_voice = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [3:0]  busy;
  logic        sound;

  int vectors = 0;
  int miscompares = 0;

  multi_voice_apu dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .trigger    (trigger),
    .cfg_we     (cfg_we),
    .cfg_voice  (cfg_voice),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .busy       (busy),
    .sound      (sound)
  );

  always #5 clk = ~clk;

  // Driver tasks: called at a falling edge, return at a later falling edge.
  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    trigger = '0;
    cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] v, input logic [1:0] m, input logic [15:0] p);
    cfg_we = 1'b1;
    cfg_voice = v;
    cfg_mode = m;
    cfg_period = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] trig, input logic tick);
    trigger = trig;
    frame_tick = tick;
    @(negedge clk);
    trigger = '0;
    frame_tick = 1'b0;
  endtask

  task automatic wait_phase0(input logic [7:0] target);
    for (int i = 0; i < 1200; i++) begin
      if (dut.g_voice[0].u_voice.phase == target) return;
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_phase0: phase stuck at %0d, required to reach %0d",
             dut.g_voice[0].u_voice.phase, target);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sound !== 1'b0) begin
      miscompares++; $display("FAIL reset_sound: got %0b expected 0", sound);
    end
    vectors++;
    if (busy !== 4'b0000) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0000", busy);
    end
    vectors++;
    if (dut.lfsr !== 13'h0E1F) begin
      miscompares++; $display("FAIL reset_lfsr: got %h expected 0e1f", dut.lfsr);
    end
    vectors++;
    if (dut.pwm_level !== 10'd0) begin
      miscompares++; $display("FAIL reset_pwm_level: got %0d expected 0", dut.pwm_level);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (dut.lfsr !== 13'h1C3F) begin
      miscompares++; $display("FAIL lfsr_step: got %h expected 1c3f", dut.lfsr);
    end
    vectors++;
    if (dut.pwm_cnt !== 10'd1) begin
      miscompares++; $display("FAIL pwm_cnt_start: got %0d expected 1", dut.pwm_cnt);
    end
  endtask

  task automatic test_saw();
    cfg_write(3'd0, 2'b00, 16'd4);
    pulse(4'b0001, 1'b0);
    wait_phase0(8'd100);
    @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.sample !== 8'd96) begin
      miscompares++; $display("FAIL saw_sample: got %0d expected 96", dut.g_voice[0].u_voice.sample);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd100) begin
      miscompares++; $display("FAIL saw_hold: got %0d expected 100", dut.g_voice[0].u_voice.phase);
    end
    @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd101) begin
      miscompares++; $display("FAIL saw_step: got %0d expected 101", dut.g_voice[0].u_voice.phase);
    end
    repeat (1024) @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd101) begin
      miscompares++; $display("FAIL saw_256_steps: got %0d expected 101", dut.g_voice[0].u_voice.phase);
    end
    wait_phase0(8'd255);
    repeat (4) @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd0) begin
      miscompares++; $display("FAIL saw_wrap: got %0d expected 0", dut.g_voice[0].u_voice.phase);
    end
    wait_phase0(8'd200);
    cfg_write(3'd0, 2'b10, 16'd4);
    @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.sample !== 8'd107) begin
      miscompares++; $display("FAIL tri_sample: got %0d expected 107", dut.g_voice[0].u_voice.sample);
    end
    vectors++;
    if (busy !== 4'b0001) begin
      miscompares++; $display("FAIL saw_busy: got %b expected 0001", busy);
    end
  endtask

  task automatic test_envelope();
    pulse(4'b0010, 1'b0);
    vectors++;
    if (dut.g_voice[1].u_voice.env !== 5'd31) begin
      miscompares++; $display("FAIL env_full: got %0d expected 31", dut.g_voice[1].u_voice.env);
    end
    for (int t = 1; t <= 31; t++) begin
      pulse(4'b0000, 1'b1);
      vectors++;
      if (busy[1] !== (t <= 30)) begin
        miscompares++; $display("FAIL env_busy_tick%0d: got %0b expected %0b", t, busy[1], (t <= 30));
      end
      if (t == 5) begin
        vectors++;
        if (dut.g_voice[1].u_voice.env !== 5'd26) begin
          miscompares++; $display("FAIL env_tick5: got %0d expected 26", dut.g_voice[1].u_voice.env);
        end
      end
    end
    pulse(4'b0000, 1'b1);
    vectors++;
    if (dut.g_voice[1].u_voice.env !== 5'd0) begin
      miscompares++; $display("FAIL env_saturate: got %0d expected 0", dut.g_voice[1].u_voice.env);
    end
  endtask

  task automatic test_coincide();
    pulse(4'b0010, 1'b1);
    vectors++;
    if (dut.g_voice[1].u_voice.env !== 5'd31) begin
      miscompares++; $display("FAIL coincide_idle: got %0d expected 31", dut.g_voice[1].u_voice.env);
    end
    repeat (3) pulse(4'b0000, 1'b1);
    vectors++;
    if (dut.g_voice[1].u_voice.env !== 5'd28) begin
      miscompares++; $display("FAIL env_after3: got %0d expected 28", dut.g_voice[1].u_voice.env);
    end
    pulse(4'b0010, 1'b1);
    vectors++;
    if (dut.g_voice[1].u_voice.env !== 5'd31) begin
      miscompares++; $display("FAIL coincide_busy: got %0d expected 31", dut.g_voice[1].u_voice.env);
    end
    pulse(4'b0001, 1'b0);
    pulse(4'b0000, 1'b1);
    wait_phase0(8'd50);
    pulse(4'b0001, 1'b0);
    vectors++;
    if (dut.g_voice[0].u_voice.env !== 5'd31) begin
      miscompares++; $display("FAIL retrig_env: got %0d expected 31", dut.g_voice[0].u_voice.env);
    end
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd50) begin
      miscompares++; $display("FAIL retrig_phase: got %0d expected 50", dut.g_voice[0].u_voice.phase);
    end
  endtask

  task automatic test_cfg();
    do_reset();
    cfg_write(3'd5, 2'b11, 16'd7);
    cfg_write(3'd4, 2'b01, 16'd9);
    @(negedge clk);
    vectors++;
    if ({dut.g_voice[0].u_voice.mode, dut.g_voice[1].u_voice.mode,
         dut.g_voice[2].u_voice.mode, dut.g_voice[3].u_voice.mode} !== 8'h00) begin
      miscompares++; $display("FAIL cfg_ignore_mode: got %h expected 00",
        {dut.g_voice[0].u_voice.mode, dut.g_voice[1].u_voice.mode,
         dut.g_voice[2].u_voice.mode, dut.g_voice[3].u_voice.mode});
    end
    vectors++;
    if ((dut.g_voice[0].u_voice.period_pend | dut.g_voice[1].u_voice.period_pend |
         dut.g_voice[2].u_voice.period_pend | dut.g_voice[3].u_voice.period_pend |
         dut.g_voice[0].u_voice.period_q | dut.g_voice[1].u_voice.period_q |
         dut.g_voice[2].u_voice.period_q | dut.g_voice[3].u_voice.period_q) !== 16'd0) begin
      miscompares++; $display("FAIL cfg_ignore_period: some period nonzero, expected all 0");
    end
    cfg_write(3'd0, 2'b00, 16'd4);
    wait_phase0(8'd3);
    cfg_write(3'd0, 2'b00, 16'd8);
    repeat (2) @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd3) begin
      miscompares++; $display("FAIL midcount_hold: got %0d expected 3", dut.g_voice[0].u_voice.phase);
    end
    @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd4) begin
      miscompares++; $display("FAIL midcount_old_period: got %0d expected 4", dut.g_voice[0].u_voice.phase);
    end
    repeat (7) @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd4) begin
      miscompares++; $display("FAIL new_period_hold: got %0d expected 4", dut.g_voice[0].u_voice.phase);
    end
    @(negedge clk);
    vectors++;
    if (dut.g_voice[0].u_voice.phase !== 8'd5) begin
      miscompares++; $display("FAIL new_period_step: got %0d expected 5", dut.g_voice[0].u_voice.phase);
    end
  endtask

  task automatic test_pwm();
    int highs;
    int i;
    do_reset();
    highs = 0;
    repeat (1100) begin
      @(negedge clk);
      if (sound === 1'b1) highs++;
    end
    vectors++;
    if (highs !== 0) begin
      miscompares++; $display("FAIL pwm_zero_level: got %0d high clocks expected 0", highs);
    end
    cfg_write(3'd2, 2'b01, 16'd1);
    pulse(4'b0100, 1'b0);
    for (i = 0; i < 300; i++) begin
      if (dut.g_voice[2].u_voice.phase >= 8'd128) break;
      @(negedge clk);
    end
    cfg_write(3'd2, 2'b01, 16'hFFFF);
    @(negedge clk);
    vectors++;
    if (dut.g_voice[2].u_voice.sample !== 8'd247) begin
      miscompares++; $display("FAIL square_scaled: got %0d expected 247", dut.g_voice[2].u_voice.sample);
    end
    for (i = 0; i < 1100; i++) begin
      if (dut.pwm_level == 10'd247) break;
      @(negedge clk);
    end
    vectors++;
    if (dut.pwm_level !== 10'd247) begin
      miscompares++; $display("FAIL pwm_level: got %0d expected 247", dut.pwm_level);
    end
    for (i = 0; i < 1100; i++) begin
      if (dut.pwm_cnt == 10'd2) break;
      @(negedge clk);
    end
    highs = 0;
    for (int k = 0; k < 1024; k++) begin
      if (sound === 1'b1) highs++;
      @(negedge clk);
    end
    vectors++;
    if (highs !== 247) begin
      miscompares++; $display("FAIL pwm_duty: got %0d high clocks expected 247", highs);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    for (i = 0; i < 1100; i++) begin
      if (sound === 1'b1) break;
      @(negedge clk);
    end
    vectors++;
    if (sound !== 1'b1 || busy[2] !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_note: sound %0b busy %b expected sound 1 busy[2] 1", sound, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (sound !== 1'b0) begin
      miscompares++; $display("FAIL async_sound: got %0b expected 0", sound);
    end
    vectors++;
    if (busy !== 4'b0000) begin
      miscompares++; $display("FAIL async_busy: got %b expected 0000", busy);
    end
    vectors++;
    if (dut.lfsr !== 13'h0E1F) begin
      miscompares++; $display("FAIL async_lfsr: got %h expected 0e1f", dut.lfsr);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_envelope();
    test_coincide();
    test_cfg();
    test_pwm();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
